// File: rtl/tmds_pkg.sv
// tmds_pkg: control-token constants shared with the transmit encoder and the rx alignment FSM state.
package tmds_pkg;
    // Control tokens indexed by {c1,c0}
    localparam logic [9:0] CTRL_TOKEN_00 = 10'b1101010100;
    localparam logic [9:0] CTRL_TOKEN_01 = 10'b0010101011;
    localparam logic [9:0] CTRL_TOKEN_10 = 10'b0101010100;
    localparam logic [9:0] CTRL_TOKEN_11 = 10'b1010101011;
    typedef enum logic [1:0] {SEARCH, SETTLE, LOCKED} rx_state_t;
endpackage

// File: rtl/tmds_symbol_decode.sv
// tmds_symbol_decode: combinational 10b TMDS symbol -> control flag, control bits and data byte.
//   sym     in  10  raw aligned symbol, bit 0 first on the wire
//   is_ctrl out 1   sym is one of the four control tokens
//   ctrl    out 2   {c1,c0} of the matched token, 0 when not a token
//   data    out 8   data-period decode (meaningful only when is_ctrl=0)
module tmds_symbol_decode
    import tmds_pkg::*;
(
    input  logic [9:0] sym,
    output logic       is_ctrl,
    output logic [1:0] ctrl,
    output logic [7:0] data
);
    logic [7:0] t;
    assign t       = sym[9] ? ~sym[7:0] : sym[7:0];
    // sym[8] selects XOR (1) or XNOR (0) transition coding
    assign data    = {sym[8] ? t[7:1] ^ t[6:0] : ~(t[7:1] ^ t[6:0]), t[0]};
    assign is_ctrl = sym inside {CTRL_TOKEN_00, CTRL_TOKEN_01, CTRL_TOKEN_10, CTRL_TOKEN_11};
    assign ctrl    = sym == CTRL_TOKEN_01 ? 2'b01 :
                     sym == CTRL_TOKEN_10 ? 2'b10 :
                     sym == CTRL_TOKEN_11 ? 2'b11 : 2'b00;
endmodule

// File: rtl/tmds_channel_rx.sv
// tmds_channel_rx: one TMDS lane receiver - bit-slip word alignment, lock tracking and symbol decode.
//   clk        in  1   pixel clock
//   rst_n      in  1   asynchronous active-low reset
//   sym_in     in  10  raw deserializer word
//   bitslip    out 1   one-cycle request to shift the deserializer word boundary
//   locked     out 1   lane aligned
//   de         out 1   data period
//   data       out 8   decoded pixel byte (valid when de=1)
//   ctrl       out 2   decoded {c1,c0} (valid when de=0)
//   slip_count out 4   slips since reset, wraps 9->0
module tmds_channel_rx
    import tmds_pkg::*;
#(
    parameter int CTRL_RUN_MIN   = 8,
    parameter int SEARCH_TIMEOUT = 1024,
    parameter int SLIP_SETTLE    = 16,
    parameter int MAX_DATA_RUN   = 1024
)(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] sym_in,
    output logic       bitslip,
    output logic       locked,
    output logic       de,
    output logic [7:0] data,
    output logic [1:0] ctrl,
    output logic [3:0] slip_count
);
    localparam int RW = $clog2(CTRL_RUN_MIN > 1 ? CTRL_RUN_MIN : 2);
    localparam int TW = $clog2(SEARCH_TIMEOUT > 1 ? SEARCH_TIMEOUT : 2);
    localparam int SW = $clog2(SLIP_SETTLE > 1 ? SLIP_SETTLE : 2);
    localparam int DW = $clog2(MAX_DATA_RUN > 1 ? MAX_DATA_RUN : 2);

    logic          d_is_ctrl;
    logic [1:0]    d_ctrl;
    logic [7:0]    d_data;
    logic          s1_is_ctrl;
    logic [1:0]    s1_ctrl;
    logic [7:0]    s1_data;
    rx_state_t     state;
    logic [RW-1:0] run;
    logic [TW-1:0] tmo;
    logic [SW-1:0] settle;
    logic [DW-1:0] drun;

    tmds_symbol_decode u_dec (
        .sym     (sym_in),
        .is_ctrl (d_is_ctrl),
        .ctrl    (d_ctrl),
        .data    (d_data)
    );

    // Counters compare against limit-1 so the transition fires on the cycle the limit is reached
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_is_ctrl <= 1'b0;
            s1_ctrl    <= '0;
            s1_data    <= '0;
            de         <= 1'b0;
            data       <= '0;
            ctrl       <= '0;
            bitslip    <= 1'b0;
            locked     <= 1'b0;
            slip_count <= '0;
            state      <= SEARCH;
            run        <= '0;
            tmo        <= '0;
            settle     <= '0;
            drun       <= '0;
        end else begin
            s1_is_ctrl <= d_is_ctrl;
            s1_ctrl    <= d_ctrl;
            s1_data    <= d_data;
            de         <= locked & ~s1_is_ctrl;
            data       <= (locked & ~s1_is_ctrl) ? s1_data : '0;
            ctrl       <= !locked ? 2'b00 : s1_is_ctrl ? s1_ctrl : ctrl;
            bitslip    <= 1'b0;
            case (state)
                SEARCH: begin
                    run <= s1_is_ctrl ? run + 1'b1 : '0;
                    tmo <= tmo + 1'b1;
                    if (s1_is_ctrl && run == RW'(CTRL_RUN_MIN - 1)) begin
                        state  <= LOCKED;
                        locked <= 1'b1;
                        run    <= '0;
                        tmo    <= '0;
                        drun   <= '0;
                    end else if (tmo == TW'(SEARCH_TIMEOUT - 1)) begin
                        state      <= SETTLE;
                        bitslip    <= 1'b1;
                        slip_count <= slip_count == 4'd9 ? 4'd0 : slip_count + 4'd1;
                        run        <= '0;
                        tmo        <= '0;
                        settle     <= '0;
                    end
                end
                SETTLE: begin
                    settle <= settle + 1'b1;
                    if (settle == SW'(SLIP_SETTLE - 1)) begin
                        state <= SEARCH;
                        run   <= '0;
                        tmo   <= '0;
                    end
                end
                LOCKED: begin
                    drun <= s1_is_ctrl ? '0 : drun + 1'b1;
                    if (!s1_is_ctrl && drun == DW'(MAX_DATA_RUN - 1)) begin
                        state  <= SEARCH;
                        locked <= 1'b0;
                        run    <= '0;
                        tmo    <= '0;
                    end
                end
                default: state <= SEARCH;
            endcase
        end
    end
endmodule
